// File: rtl/slc3_input_pkg.sv
// -----------------------------------------------------------------------------
// slc3_input_pkg
// Shared types and constants for the SLC-3 input conditioner.
//   btn_state_t             : per-button debounce FSM state
//   DEBOUNCE_CYCLES_DEFAULT : stable-cycle count needed to accept a button change
//   CNT_W                   : width of the debounce counter
// -----------------------------------------------------------------------------
package slc3_input_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd50000;
    localparam int unsigned CNT_W                   = 32'd16;

endpackage : slc3_input_pkg

// File: rtl/slc3_input_conditioner_debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One active-low pushbutton: 2-flop synchronizer, debounce FSM and counter.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high (does not touch the synchronizer)
//   btn_n  : raw asynchronous button, 0 = pressed
//   pulse  : one-cycle pulse per accepted press (registered)
//   level  : debounced button state, 1 = pressed (registered)
// -----------------------------------------------------------------------------
module debounce_channel
    import slc3_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic pulse,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic             sync1_d, sync1_q;
    logic             sync2_d, sync2_q;
    logic             pressed_s;
    btn_state_t       state_d, state_q;
    logic [CNT_W-1:0] cnt_d,   cnt_q;
    logic             pulse_d, pulse_q;
    logic             level_d, level_q;

    // Synchronizer next values: straight shift of the raw input.
    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
    end

    // Synchronizer flops: load every edge, deliberately outside reset.
    always_ff @(posedge clk) begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
    end

    assign pressed_s = ~sync2_q;

    // Debounce FSM next-state, counter and output logic.
    // level only changes when a check completes, so the post-reset
    // RELEASE_CHK state can carry level=0 without forcing it high.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = level_q;
        case (state_q)
            RELEASED: begin
                if (pressed_s) begin
                    state_d = PRESS_CHK;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = RELEASED;
                end
            end
            PRESS_CHK: begin
                if (!pressed_s) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            PRESSED: begin
                if (!pressed_s) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = PRESSED;
                end
            end
            RELEASE_CHK: begin
                if (pressed_s) begin
                    // Bounce back (or button held through reset): no pulse.
                    state_d = PRESSED;
                    level_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = RELEASE_CHK;
                cnt_d   = {CNT_W{1'b0}};
                level_d = 1'b0;
            end
        endcase
    end

    // FSM state, counter and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RELEASE_CHK;
            cnt_q   <= {CNT_W{1'b0}};
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign pulse = pulse_q;
    assign level = level_q;

endmodule : debounce_channel

// File: rtl/slc3_input_conditioner.sv
// -----------------------------------------------------------------------------
// slc3_input_conditioner
// Synchronizes and debounces raw SLC-3 board inputs.
// Ports:
//   Clk            : system clock (50 MHz), rising edge
//   Reset          : synchronous, active-high, hold >= 2 cycles
//   Run, Continue  : raw active-low pushbuttons (asynchronous)
//   SW[9:0]        : raw slide switches (asynchronous)
//   Run_pulse      : one-cycle pulse per accepted Run press
//   Continue_pulse : one-cycle pulse per accepted Continue press
//   Run_level      : debounced Run, 1 = pressed
//   Continue_level : debounced Continue, 1 = pressed
//   SW_sync[9:0]   : 2-flop synchronized switches (not reset)
// -----------------------------------------------------------------------------
module slc3_input_conditioner
    import slc3_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [9:0] SW,
    output logic       Run_pulse,
    output logic       Continue_pulse,
    output logic       Run_level,
    output logic       Continue_level,
    output logic [9:0] SW_sync
);

    logic [9:0] sw1_d, sw1_q;
    logic [9:0] sw2_d, sw2_q;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run (
        .clk   (Clk),
        .reset (Reset),
        .btn_n (Run),
        .pulse (Run_pulse),
        .level (Run_level)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_continue (
        .clk   (Clk),
        .reset (Reset),
        .btn_n (Continue),
        .pulse (Continue_pulse),
        .level (Continue_level)
    );

    // Switch synchronizer next values.
    always_comb begin
        sw1_d = SW;
        sw2_d = sw1_q;
    end

    // Switch synchronizer flops: free-running, no reset.
    always_ff @(posedge Clk) begin
        sw1_q <= sw1_d;
        sw2_q <= sw2_d;
    end

    assign SW_sync = sw2_q;

endmodule : slc3_input_conditioner

// File: tb/tb_slc3_input_conditioner.sv
module tb_slc3_input_conditioner;

    localparam int D = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic       Continue;
    logic [9:0] SW;
    logic       Run_pulse, Continue_pulse, Run_level, Continue_level;
    logic [9:0] SW_sync;

    slc3_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Run            (Run),
        .Continue       (Continue),
        .SW             (SW),
        .Run_pulse      (Run_pulse),
        .Continue_pulse (Continue_pulse),
        .Run_level      (Run_level),
        .Continue_level (Continue_level),
        .SW_sync        (SW_sync)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    // Reference model: per channel, the delayed view of the raw button, the
    // debounced level, a run-length of samples disagreeing with the level,
    // and a "resolving" flag for the period right after reset.
    bit   m_s1[2];
    bit   m_s2[2];
    bit   m_lvl[2];
    bit   m_res[2];
    bit   m_pulse[2];
    int   m_cnt[2];
    logic [9:0] m_sw1, m_sw2;

    int run_pulses, cont_pulses, run_edge, cont_edge, run_fall_edge;
    bit prev_run_level;

    task automatic model_edge();
        bit raw[2];
        bit pr;
        raw[0] = Run;
        raw[1] = Continue;
        for (int ch = 0; ch < 2; ch++) begin
            pr = !m_s2[ch];
            m_pulse[ch] = 1'b0;
            if (Reset) begin
                m_lvl[ch] = 1'b0;
                m_cnt[ch] = 0;
                m_res[ch] = 1'b1;
            end else if (m_res[ch]) begin
                // After reset: held button is taken as pressed silently,
                // a released one settles after D released samples.
                if (pr) begin
                    m_lvl[ch] = 1'b1;
                    m_res[ch] = 1'b0;
                    m_cnt[ch] = 0;
                end else begin
                    m_cnt[ch]++;
                    if (m_cnt[ch] == D) begin
                        m_res[ch] = 1'b0;
                        m_cnt[ch] = 0;
                    end
                end
            end else if (pr != m_lvl[ch]) begin
                // D+1 consecutive disagreeing samples flip the level.
                m_cnt[ch]++;
                if (m_cnt[ch] == D + 1) begin
                    m_lvl[ch]   = pr;
                    m_cnt[ch]   = 0;
                    m_pulse[ch] = pr;
                end
            end else begin
                m_cnt[ch] = 0;
            end
            m_s2[ch] = m_s1[ch];
            m_s1[ch] = raw[ch];
        end
        m_sw2 = m_sw1;
        m_sw1 = SW;
    endtask

    task automatic check_v(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            model_edge();
            edges++;
            #1;
            check_v("run_pulse",  10'(Run_pulse),      10'(m_pulse[0]));
            check_v("cont_pulse", 10'(Continue_pulse), 10'(m_pulse[1]));
            check_v("run_level",  10'(Run_level),      10'(m_lvl[0]));
            check_v("cont_level", 10'(Continue_level), 10'(m_lvl[1]));
            if (edges >= 2) check_v("sw_sync", SW_sync, m_sw2);
            if (Run_pulse === 1'b1) begin
                run_pulses++;
                run_edge = edges;
            end
            if (Continue_pulse === 1'b1) begin
                cont_pulses++;
                cont_edge = edges;
            end
            if (prev_run_level && Run_level === 1'b0) run_fall_edge = edges;
            prev_run_level = (Run_level === 1'b1);
        end
    endtask

    task automatic clear_counts();
        run_pulses  = 0;
        cont_pulses = 0;
        run_edge    = -1;
        cont_edge   = -1;
    endtask

    initial begin
        int start;
        for (int ch = 0; ch < 2; ch++) begin
            m_s1[ch] = 1'b1; m_s2[ch] = 1'b1; m_lvl[ch] = 1'b0;
            m_res[ch] = 1'b1; m_pulse[ch] = 1'b0; m_cnt[ch] = 0;
        end
        m_sw1 = 10'h000; m_sw2 = 10'h000;
        prev_run_level = 1'b0;
        run_fall_edge  = -1;
        clear_counts();

        // Reset with both buttons released, then idle.
        Reset = 1'b1; Run = 1'b1; Continue = 1'b1; SW = 10'h000;
        step(2);
        Reset = 1'b0;
        step(10);
        check_i("idle_run_level",  int'(Run_level), 0);
        check_i("idle_pulses",     run_pulses + cont_pulses, 0);

        // Clean Run press, held 30 cycles.
        clear_counts();
        start = edges;
        Run = 1'b0;
        step(30);
        check_i("press_pulse_count", run_pulses, 1);
        check_i("press_pulse_edge",  run_edge - start, D + 3);
        check_i("press_cont_quiet",  cont_pulses, 0);
        Run = 1'b1;
        step(12);

        // Bounce: low 3, high 1, then low held.
        clear_counts();
        Run = 1'b0; step(3);
        Run = 1'b1; step(1);
        Run = 1'b0;
        start = edges;
        step(20);
        check_i("bounce_pulse_count", run_pulses, 1);
        check_i("bounce_pulse_edge",  run_edge - start, D + 3);

        // Short release glitch while pressed, then a real release.
        clear_counts();
        Run = 1'b1; step(2);
        Run = 1'b0; step(10);
        check_i("glitch_level", int'(Run_level), 1);
        check_i("glitch_no_pulse", run_pulses, 0);
        Run = 1'b1;
        start = edges;
        step(12);
        check_i("release_fall_edge", run_fall_edge - start, D + 3);

        // Simultaneous presses.
        clear_counts();
        Run = 1'b0; Continue = 1'b0;
        step(15);
        check_i("both_run_pulses",  run_pulses, 1);
        check_i("both_cont_pulses", cont_pulses, 1);
        check_i("both_same_cycle",  run_edge, cont_edge);
        Run = 1'b1; Continue = 1'b1;
        step(12);

        // Run held through a 3-cycle reset: level without pulse.
        clear_counts();
        Run = 1'b0; Reset = 1'b1;
        step(3);
        Reset = 1'b0;
        step(10);
        check_i("chord_level", int'(Run_level), 1);
        check_i("chord_no_pulse", run_pulses, 0);
        Run = 1'b1; step(12);
        Run = 1'b0; step(15);
        check_i("chord_repress_pulse", run_pulses, 1);
        Run = 1'b1; step(12);

        // Switch synchronizer latency.
        SW = 10'h09C;
        step(1);
        check_v("sw_one_edge", SW_sync, 10'h000);
        step(1);
        check_v("sw_two_edges", SW_sync, 10'h09C);

        // Randomized stimulus with occasional resets.
        for (int seg = 0; seg < 120; seg++) begin
            if ($urandom_range(0, 19) == 0) begin
                Reset = 1'b1;
                step(int'($urandom_range(2, 3)));
                Reset = 1'b0;
            end
            Run      = 1'($urandom_range(0, 1));
            Continue = 1'($urandom_range(0, 1));
            SW       = 10'($urandom);
            step(int'($urandom_range(1, 11)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_slc3_input_conditioner
